// File: rtl/flash_latency_ctrl.sv
// flash_latency_ctrl
//   Measures display-to-sensor latency. After the sensor has seen a run of
//   dark frames, the controller asks for a white flash and counts ticks
//   until the light sensor reports light, or until a timeout.
//
//   Optional feature: define FLASH_LATENCY_MINMAX_EN to track min/max of
//   all results since reset. Without it, min_ticks/max_ticks are tied to 0.
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   start         single-cycle request for one measurement (ignored unless idle)
//   continuous    level; re-arms automatically after each result/timeout
//   abort         single-cycle cancel, highest priority after reset
//   frame_start   single-cycle pulse per video frame (clk domain)
//   sensor_on     debounced light-sensor level
//   flash         high exactly while measuring (pattern drawn white)
//   busy          high whenever not idle
//   result_valid  single-cycle pulse when result_ticks is updated
//   result_ticks  last measured latency in ticks
//   timeout       single-cycle pulse when a measurement is abandoned
//   min_ticks     smallest result since reset (feature build only)
//   max_ticks     largest result since reset (feature build only)
//   state_dbg     current FSM state (0 IDLE, 1 DARK, 2 MEASURE, 3 COOL)
//
// Handshake: all inputs are sampled on the rising clk edge; result_valid and
//   timeout are one-cycle strobes with no back-pressure, and result_ticks is
//   stable from the result_valid cycle until the next result or reset.
module flash_latency_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int TICK_HZ       = 10_000,
    parameter int SETTLE_FRAMES = 4,
    parameter int TIMEOUT_TICKS = 10_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    input  logic        frame_start,
    input  logic        sensor_on,
    output logic        flash,
    output logic        busy,
    output logic        result_valid,
    output logic [15:0] result_ticks,
    output logic        timeout,
    output logic [15:0] min_ticks,
    output logic [15:0] max_ticks,
    output logic [1:0]  state_dbg
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [7:0]    SETTLE     = 8'(SETTLE_FRAMES);
    localparam logic [15:0]   TMO        = 16'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DARK    = 2'd1,
        MEASURE = 2'd2,
        COOL    = 2'd3
    } state_t;

    state_t          state;
    logic [7:0]      dark_cnt;
    logic [PW-1:0]   presc;
    logic [15:0]     lat;
    logic            cool_dark;   // sensor seen dark since entering COOL

    logic tick;
    logic capture;

    assign tick      = (presc == PRESC_LAST);
    // Light seen while measuring; a result beats a coincident timeout.
    assign capture   = (state == MEASURE) && sensor_on && !abort;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dark_cnt     <= '0;
            presc        <= '0;
            lat          <= '0;
            cool_dark    <= 1'b0;
            flash        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            result_ticks <= '0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (abort) begin
                state <= IDLE;
                flash <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start || continuous) begin
                            state    <= DARK;
                            busy     <= 1'b1;
                            dark_cnt <= '0;
                        end
                    end
                    DARK: begin
                        // Light restarts the dark run; the frame after a full
                        // run of dark frames launches the flash.
                        if (sensor_on) begin
                            dark_cnt <= '0;
                        end else if (frame_start) begin
                            if (dark_cnt == SETTLE) begin
                                state <= MEASURE;
                                flash <= 1'b1;
                                presc <= '0;
                                lat   <= '0;
                            end else begin
                                dark_cnt <= dark_cnt + 8'd1;
                            end
                        end
                    end
                    MEASURE: begin
                        if (capture) begin
                            result_ticks <= lat;
                            result_valid <= 1'b1;
                            state        <= COOL;
                            flash        <= 1'b0;
                            cool_dark    <= 1'b0;
                        end else if (lat == TMO) begin
                            timeout   <= 1'b1;
                            state     <= COOL;
                            flash     <= 1'b0;
                            cool_dark <= 1'b0;
                        end else if (tick) begin
                            presc <= '0;
                            if (lat != 16'hFFFF) lat <= lat + 16'd1;
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    COOL: begin
                        if (!sensor_on) cool_dark <= 1'b1;
                        // Leave only once the pattern has gone dark again and
                        // a new frame has begun.
                        if (frame_start && cool_dark && !sensor_on) begin
                            if (continuous) begin
                                state    <= DARK;
                                dark_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        flash <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FLASH_LATENCY_MINMAX_EN
    logic have_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            min_ticks   <= '0;
            max_ticks   <= '0;
            have_result <= 1'b0;
        end else if (capture) begin
            if (!have_result) begin
                min_ticks   <= lat;
                max_ticks   <= lat;
                have_result <= 1'b1;
            end else begin
                if (lat < min_ticks) min_ticks <= lat;
                if (lat > max_ticks) max_ticks <= lat;
            end
        end
    end
`else
    assign min_ticks = '0;
    assign max_ticks = '0;
`endif

endmodule

// File: tb/tb_flash_latency_ctrl.sv
// Testbench for flash_latency_ctrl with a 10-cycle tick, 2 settle frames,
// 50-tick timeout and a frame_start pulse every 200 cycles.
// Expected results go into exp_q when stimulus is issued; a monitor pops and
// compares on every result_valid / timeout strobe.
// exp_q entry: bit 16 = 1 for timeout, 0 for result; bits 15:0 = result_ticks.
module tb_flash_latency_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic        frame_start = 1'b0;
    logic        sensor_on = 1'b0;
    logic        flash;
    logic        busy;
    logic        result_valid;
    logic [15:0] result_ticks;
    logic        timeout;
    logic [15:0] min_ticks;
    logic [15:0] max_ticks;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];

    flash_latency_ctrl #(
        .CLK_HZ(1000),
        .TICK_HZ(100),
        .SETTLE_FRAMES(2),
        .TIMEOUT_TICKS(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .continuous(continuous),
        .abort(abort),
        .frame_start(frame_start),
        .sensor_on(sensor_on),
        .flash(flash),
        .busy(busy),
        .result_valid(result_valid),
        .result_ticks(result_ticks),
        .timeout(timeout),
        .min_ticks(min_ticks),
        .max_ticks(max_ticks),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / frame generator ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (199) @(posedge clk);
            #1 frame_start = 1'b1;
            @(posedge clk);
            #1 frame_start = 1'b0;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && (result_valid || timeout)) begin
            logic [16:0] e;
            logic [16:0] a;
            checks++;
            a = {timeout, result_ticks};
            if (result_valid && timeout) begin
                errors++;
                $display("FAIL strobe_both actual=rv1_to1 required=one_strobe");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe actual=%h required=none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb_result actual=kind%0d_ticks%0d required=kind%0d_ticks%0d",
                             a[16], a[15:0], e[16], e[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Returns in the first cycle flash is high (cycle 0 of MEASURE).
    task automatic wait_flash_rise(input string name);
        int n = 0;
        while (!flash && n < 1200) begin
            step();
            n++;
        end
        if (!flash) begin
            checks++;
            errors++;
            $display("FAIL %s_flash_timeout actual=0 required=1", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 1200) begin
            step();
            n++;
        end
        chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_idle_state"}, {30'd0, state_dbg}, 32'd0);
    endtask

    task automatic wait_frame();
        int n = 0;
        step();
        while (!frame_start && n < 250) begin
            step();
            n++;
        end
        if (!frame_start) begin
            checks++;
            errors++;
            $display("FAIL frame_wait actual=0 required=1");
        end
    endtask

    // Light arrives in MEASURE cycle n; released one cycle later.
    task automatic light_at(input int n, input logic [15:0] exp_ticks);
        repeat (n) step();
        sensor_on = 1'b1;
        exp_q.push_back({1'b0, exp_ticks});
        step();
        sensor_on = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] exp_min;
        logic [15:0] exp_max;
        int n;

        repeat (3) step();
        chk("rst_flash", {31'd0, flash}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_result_ticks", {16'd0, result_ticks}, 32'd0);
        chk("rst_min", {16'd0, min_ticks}, 32'd0);
        chk("rst_max", {16'd0, max_ticks}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        reset = 1'b0;
        step();

        // Single shot: light 125 cycles after flash -> 12 ticks, flash drops next cycle.
        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);
        wait_flash_rise("t125");
        repeat (125) step();
        sensor_on = 1'b1;
        exp_q.push_back({1'b0, 16'd12});
        step();
        chk("t125_flash_fall", {31'd0, flash}, 32'd0);
        chk("t125_rv", {31'd0, result_valid}, 32'd1);
        sensor_on = 1'b0;
        step();
        chk("t125_rv_single", {31'd0, result_valid}, 32'd0);
        wait_idle("t125");

        // Light in the same cycle the count reaches 50: result wins.
        pulse_start();
        wait_flash_rise("t500");
        light_at(500, 16'd50);
        chk("t500_timeout_low", {31'd0, timeout}, 32'd0);
        wait_idle("t500");

        // No light: count reaches 50 in cycle 500, pulse registered in cycle 501.
        pulse_start();
        wait_flash_rise("tmo");
        exp_q.push_back({1'b1, 16'd50});
        n = 0;
        while (!timeout && n < 600) begin
            step();
            n++;
        end
        chk("tmo_cycle", n, 32'd501);
        step();
        chk("tmo_single", {31'd0, timeout}, 32'd0);
        chk("tmo_flash", {31'd0, flash}, 32'd0);
        chk("tmo_cool_busy", {31'd0, busy}, 32'd1);
        wait_idle("tmo");

        // Light during the second dark frame restarts the dark run.
        wait_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_frame();                    // dark frame 1
        wait_frame();                    // light -> counter cleared
        sensor_on = 1'b1;
        step();
        sensor_on = 1'b0;
        wait_frame();                    // dark frame 1 again
        chk("dark_c_flash", {31'd0, flash}, 32'd0);
        wait_frame();                    // dark frame 2
        chk("dark_d_flash", {31'd0, flash}, 32'd0);
        wait_frame();                    // launches flash
        chk("dark_e_flash", {31'd0, flash}, 32'd0);
        step();
        chk("dark_e_flash_rise", {31'd0, flash}, 32'd1);
        light_at(49, 16'd4);             // flash rose one cycle before this point
        wait_idle("dark");

`ifdef FLASH_LATENCY_MINMAX_EN
        exp_min = 16'd4;
        exp_max = 16'd50;
`else
        exp_min = 16'd0;
        exp_max = 16'd0;
`endif

        // Abort mid-measure: no strobe, result_ticks keeps 4.
        pulse_start();
        wait_flash_rise("abort");
        repeat (30) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_flash", {31'd0, flash}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ticks", {16'd0, result_ticks}, 32'd4);
        sensor_on = 1'b1;
        repeat (20) step();
        sensor_on = 1'b0;
        chk("abort_min", {16'd0, min_ticks}, {16'd0, exp_min});
        chk("abort_max", {16'd0, max_ticks}, {16'd0, exp_max});

        // Reset mid-measure: everything cleared.
        pulse_start();
        wait_flash_rise("rstm");
        repeat (30) step();
        reset = 1'b1;
        step();
        chk("rstm_flash", {31'd0, flash}, 32'd0);
        chk("rstm_busy", {31'd0, busy}, 32'd0);
        chk("rstm_ticks", {16'd0, result_ticks}, 32'd0);
        do_reset();

        // Continuous: latencies 7, 3, 9 ticks.
        continuous = 1'b1;
        step();
        wait_flash_rise("cont0");
        light_at(75, 16'd7);
        wait_flash_rise("cont1");
        light_at(35, 16'd3);
        wait_flash_rise("cont2");
        light_at(95, 16'd9);
        continuous = 1'b0;
        wait_idle("cont");
`ifdef FLASH_LATENCY_MINMAX_EN
        exp_min = 16'd3;
        exp_max = 16'd9;
`else
        exp_min = 16'd0;
        exp_max = 16'd0;
`endif
        chk("cont_min", {16'd0, min_ticks}, {16'd0, exp_min});
        chk("cont_max", {16'd0, max_ticks}, {16'd0, exp_max});
        chk("cont_ticks", {16'd0, result_ticks}, 32'd9);

        repeat (5) step();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
